prio_rsp_router: RTL and testbench
==================================

Name: prio_rsp_router

Overview:
- Return-path companion to the priority arbiter. It records the winning port index of every accepted grant in an in-order outstanding-transaction queue.
- It routes the single shared response stream back to the originating requester port using a valid/ready handshake per port.
- It sits between the shared slave/response channel and the NUM_REQ requester ports.
- gnt_ready_o is fed back to the arbiter enable so grants stop when the queue is full.

Parameters:
- NUM_REQ, 13, number of requester ports; must be >= 2.
- DEPTH, 4, maximum outstanding grants awaiting response; must be >= 1.
- IDX_W, $clog2(NUM_REQ), derived, width of the port index.
- CNT_W, $clog2(DEPTH+1), derived, width of the outstanding counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of all outstanding state.
- gnt_i  in  1  arbiter grant accepted this cycle (arbiter vld & en).
- gnt_idx_i  in  IDX_W  index of the granted port.
- gnt_ready_o  out  1  queue can accept a grant (not full).
- rsp_valid_i  in  1  shared response valid.
- rsp_ready_o  out  1  shared response accepted.
- rsp_valid_o  out  NUM_REQ  per-port response valid; at most one bit set.
- rsp_ready_i  in  NUM_REQ  per-port response ready.
- outstanding_o  out  CNT_W  number of queued grants.
- empty_o  out  1  no outstanding grants.

Behaviour:
- Storage: circular FIFO of DEPTH entries, each IDX_W wide, with wr_ptr, rd_ptr and a count. Pointers wrap from DEPTH-1 to 0; non-power-of-2 DEPTH is supported.
- Reset (async): wr_ptr = 0, rd_ptr = 0, count = 0. Outputs then read gnt_ready_o = 1, rsp_ready_o = 0, rsp_valid_o = 0, outstanding_o = 0, empty_o = 1.
- Push:
  - Occurs when gnt_i & gnt_ready_o: mem[wr_ptr] <= gnt_idx_i, then wr_ptr advances.
  - gnt_ready_o = (count != DEPTH) and depends on registered state only; no combinational path from the response side.
  - gnt_i while full is ignored. This is a protocol violation flagged by an assertion; state is unchanged.
- Head and routing:
  - head = mem[rd_ptr].
  - When empty: rsp_valid_o = 0 and rsp_ready_o = 0; the response is stalled.
  - When not empty: rsp_valid_o[head] = rsp_valid_i, other bits 0; rsp_ready_o = rsp_ready_i[head].
  - Routing is purely combinational, zero-cycle latency.
- Illegal head index (head >= NUM_REQ):
  - rsp_valid_o = 0 and rsp_ready_o = 1, so the response is drained and dropped rather than deadlocking.
  - An assertion flags it at push time.
- Pop: when rsp_valid_i & rsp_ready_o, rd_ptr advances.
- Count: count_d = count + push - pop. Push and pop in the same cycle leave count unchanged and both pointers advance.
- No fall-through: a grant pushed in cycle t is routable from cycle t+1 at the earliest. A response arriving in cycle t while empty waits.
- Full and pop in the same cycle: gnt_ready_o stays 0 that cycle and the push is taken in the next cycle.
- flush_i:
  - Clears pointers and count on the next edge.
  - Has priority over any push or pop in the same cycle.
  - Outputs in the flush cycle are still driven from current state.
- Reset mid-transaction: all queued indices are lost and in-flight responses are not routed after reset.
- outstanding_o = count; empty_o = (count == 0). Both are registered-state derived.
- Ordering: responses are strictly in grant order; no reordering or ID matching.
- Assertions (simulation only): gnt_i & !gnt_ready_o; gnt_idx_i >= NUM_REQ on push; $onehot0(rsp_valid_o).

Test Plan:
- Reset, then idle with rsp_valid_i = 1 → rsp_valid_o = 0, rsp_ready_o = 0, empty_o = 1, gnt_ready_o = 1.
- Grants idx 3, 0, 12 on consecutive cycles; responses with all rsp_ready_i = 1 → rsp_valid_o = 0x008, then 0x001, then 0x1000 in order. outstanding_o goes 1, 2, 3, then drains to 0.
- DEPTH = 4 filled with idx 5, 5, 7, 1 → gnt_ready_o = 0, outstanding_o = 4. Simultaneous pop plus gnt_i: the grant is not taken; the next cycle gnt_ready_o = 1 and it is taken.
- Head idx 7 with rsp_ready_i[7] = 0 for 3 cycles while rsp_ready_i[other] = 1 → rsp_ready_o = 0, no pop. Raising ready[7] gives exactly one pop.
- Push and pop every cycle for 20 cycles with DEPTH = 3 (pointer wrap) → count stays 1 and the routed idx sequence equals the grant sequence delayed.
- 2 entries outstanding plus flush_i together with gnt_i → next cycle outstanding_o = 0, empty_o = 1. The async rst_ni pulse mid-stream gives the same result.

Source files
------------

// File: rtl/prio_rsp_router.sv
// prio_rsp_router: in-order return-path router for a priority arbiter.
// Revision 1.0 - initial release.
`default_nettype none

module prio_rsp_router #(
  parameter  int NUM_REQ = 13,
  parameter  int DEPTH   = 4,
  localparam int IDX_W   = $clog2(NUM_REQ),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               gnt_i,
  input  logic [IDX_W-1:0]   gnt_idx_i,
  output logic               gnt_ready_o,
  input  logic               rsp_valid_i,
  output logic               rsp_ready_o,
  output logic [NUM_REQ-1:0] rsp_valid_o,
  input  logic [NUM_REQ-1:0] rsp_ready_i,
  output logic [CNT_W-1:0]   outstanding_o,
  output logic               empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             empty;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] head;
  logic             head_legal;

  // Pointers wrap explicitly so a non-power-of-2 DEPTH never walks off the array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (count == '0);
  assign gnt_ready_o = (count != FULL_CNT);
  assign push        = gnt_i & gnt_ready_o;
  assign pop         = rsp_valid_i & rsp_ready_o;

  assign head        = mem[rd_ptr];
  assign head_legal  = (int'(head) < NUM_REQ);

  assign outstanding_o = count;
  assign empty_o       = empty;

  // An illegal head index is drained (ready=1, no valid) so the response path cannot deadlock.
  always_comb begin
    rsp_valid_o = '0;
    rsp_ready_o = 1'b0;
    if (!empty) begin
      if (head_legal) begin
        rsp_valid_o[head] = rsp_valid_i;
        rsp_ready_o       = rsp_ready_i[head];
      end else begin
        rsp_ready_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr] <= gnt_idx_i;
  end

`ifndef SYNTHESIS
  a_no_gnt_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(gnt_i && !gnt_ready_o));
  a_legal_push_idx : assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (int'(gnt_idx_i) < NUM_REQ));
  a_onehot_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rsp_valid_o));
`endif

endmodule

`default_nettype wire

// File: tb/tb_prio_rsp_router.sv
// tb_prio_rsp_router: directed self-checking bench for prio_rsp_router.
// Revision 1.0 - initial release.
`default_nettype none

module tb_prio_rsp_router;

  localparam int NREQ = 13;

  logic        clk = 1'b0;
  logic        rst_n;

  // DEPTH = 4 instance
  logic        flush, gnt, gnt_ready, rsp_valid, rsp_ready_up, empty;
  logic [3:0]  gnt_idx;
  logic [12:0] rsp_valid_dn, rsp_ready_dn;
  logic [2:0]  outstanding;

  // DEPTH = 3 instance
  logic        flush3, gnt3, gnt_ready3, rsp_valid3, rsp_ready_up3, empty3;
  logic [3:0]  gnt_idx3;
  logic [12:0] rsp_valid_dn3, rsp_ready_dn3;
  logic [1:0]  outstanding3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prio_rsp_router #(.NUM_REQ(NREQ), .DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .gnt_i(gnt), .gnt_idx_i(gnt_idx), .gnt_ready_o(gnt_ready),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready_up),
    .rsp_valid_o(rsp_valid_dn), .rsp_ready_i(rsp_ready_dn),
    .outstanding_o(outstanding), .empty_o(empty)
  );

  prio_rsp_router #(.NUM_REQ(NREQ), .DEPTH(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush3),
    .gnt_i(gnt3), .gnt_idx_i(gnt_idx3), .gnt_ready_o(gnt_ready3),
    .rsp_valid_i(rsp_valid3), .rsp_ready_o(rsp_ready_up3),
    .rsp_valid_o(rsp_valid_dn3), .rsp_ready_i(rsp_ready_dn3),
    .outstanding_o(outstanding3), .empty_o(empty3)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    flush = 0; gnt = 0; gnt_idx = '0; rsp_valid = 1'b1; rsp_ready_dn = '1;
    flush3 = 0; gnt3 = 0; gnt_idx3 = '0; rsp_valid3 = 0; rsp_ready_dn3 = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (rsp_valid_dn !== 13'h0) begin errors++; $display("FAIL reset_valid: got %h want %h", rsp_valid_dn, 13'h0); end
    checks++; if (rsp_ready_up !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", rsp_ready_up); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (gnt_ready !== 1'b1) begin errors++; $display("FAIL reset_gnt_ready: got %b want 1", gnt_ready); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  task automatic test_order;
    // Grant 3 while a response is already waiting: it must not fall through.
    gnt = 1; gnt_idx = 4'd3; rsp_valid = 1;
    #1;
    checks++; if (rsp_valid_dn !== 13'h0 || rsp_ready_up !== 1'b0) begin errors++; $display("FAIL no_fallthrough: got v=%h r=%b want 0000 0", rsp_valid_dn, rsp_ready_up); end
    @(negedge clk);
    rsp_valid = 0; gnt_idx = 4'd0;
    #1;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL order_cnt1: got %0d want 1", outstanding); end
    @(negedge clk);
    gnt_idx = 4'd12;
    #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL order_cnt2: got %0d want 2", outstanding); end
    @(negedge clk);
    gnt = 0; gnt_idx = '0; rsp_valid = 1; rsp_ready_dn = '1;
    #1;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL order_cnt3: got %0d want 3", outstanding); end
    checks++; if (rsp_valid_dn !== 13'h0008) begin errors++; $display("FAIL order_rsp0: got %h want 0008", rsp_valid_dn); end
    checks++; if (rsp_ready_up !== 1'b1) begin errors++; $display("FAIL order_ready0: got %b want 1", rsp_ready_up); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid_dn !== 13'h0001 || outstanding !== 3'd2) begin errors++; $display("FAIL order_rsp1: got %h/%0d want 0001/2", rsp_valid_dn, outstanding); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid_dn !== 13'h1000 || outstanding !== 3'd1) begin errors++; $display("FAIL order_rsp2: got %h/%0d want 1000/1", rsp_valid_dn, outstanding); end
    @(negedge clk);
    rsp_valid = 0;
    #1;
    checks++; if (outstanding !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL order_drained: got %0d/%b want 0/1", outstanding, empty); end
  endtask

  task automatic test_full;
    logic [3:0] fill [4] = '{4'd5, 4'd5, 4'd7, 4'd1};
    logic       req;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gnt = 1; gnt_idx = fill[i];
    end
    @(negedge clk);
    gnt = 0;
    #1;
    checks++; if (gnt_ready !== 1'b0 || outstanding !== 3'd4) begin errors++; $display("FAIL full_state: got rdy=%b cnt=%0d want 0/4", gnt_ready, outstanding); end
    // Arbiter request for idx 2 is gated by gnt_ready while a pop happens.
    req = 1'b1; gnt_idx = 4'd2; rsp_valid = 1; rsp_ready_dn = '1;
    gnt = req & gnt_ready;
    #1;
    checks++; if (gnt_ready !== 1'b0 || rsp_valid_dn !== 13'h0020) begin errors++; $display("FAIL full_pop: got rdy=%b v=%h want 0/0020", gnt_ready, rsp_valid_dn); end
    @(negedge clk);
    rsp_valid = 0;
    gnt = req & gnt_ready;
    #1;
    checks++; if (gnt_ready !== 1'b1 || outstanding !== 3'd3) begin errors++; $display("FAIL full_reopen: got rdy=%b cnt=%0d want 1/3", gnt_ready, outstanding); end
    @(negedge clk);
    gnt = 0; gnt_idx = '0;
    #1;
    checks++; if (outstanding !== 3'd4 || gnt_ready !== 1'b0) begin errors++; $display("FAIL full_retaken: got cnt=%0d rdy=%b want 4/0", outstanding, gnt_ready); end
  endtask

  task automatic test_stall;
    // Queue holds 5,7,1,2: drop the 5 so idx 7 is at the head.
    rsp_valid = 1; rsp_ready_dn = '1;
    @(negedge clk);
    rsp_ready_dn = 13'h1FFF & ~13'h0080;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rsp_ready_up !== 1'b0 || rsp_valid_dn !== 13'h0080 || outstanding !== 3'd3) begin errors++; $display("FAIL stall_%0d: got r=%b v=%h cnt=%0d want 0/0080/3", i, rsp_ready_up, rsp_valid_dn, outstanding); end
      @(negedge clk);
    end
    rsp_ready_dn = '1;
    #1;
    checks++; if (rsp_ready_up !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", rsp_ready_up); end
    @(negedge clk);
    rsp_valid = 0;
    #1;
    checks++; if (outstanding !== 3'd2 || rsp_valid_dn !== 13'h0) begin errors++; $display("FAIL stall_one_pop: got cnt=%0d v=%h want 2/0000", outstanding, rsp_valid_dn); end
  endtask

  task automatic test_flush;
    // Two entries (1,2) outstanding; flush wins over the concurrent push and pop.
    flush = 1; gnt = 1; gnt_idx = 4'd4; rsp_valid = 1;
    #1;
    checks++; if (rsp_valid_dn !== 13'h0002 || outstanding !== 3'd2) begin errors++; $display("FAIL flush_cycle: got v=%h cnt=%0d want 0002/2", rsp_valid_dn, outstanding); end
    @(negedge clk);
    flush = 0; gnt = 0; gnt_idx = '0;
    #1;
    checks++; if (outstanding !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_clear: got cnt=%0d e=%b want 0/1", outstanding, empty); end
    checks++; if (rsp_valid_dn !== 13'h0 || rsp_ready_up !== 1'b0) begin errors++; $display("FAIL flush_no_route: got v=%h r=%b want 0000/0", rsp_valid_dn, rsp_ready_up); end
    @(negedge clk);
    rsp_valid = 0;
  endtask

  task automatic test_reset_mid;
    gnt = 1; gnt_idx = 4'd9;
    @(negedge clk);
    gnt_idx = 4'd10;
    @(negedge clk);
    gnt = 0; gnt_idx = '0;
    #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL rst_mid_pre: got %0d want 2", outstanding); end
    rst_n = 0;
    #1;
    checks++; if (outstanding !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL rst_mid_async: got cnt=%0d e=%b want 0/1", outstanding, empty); end
    @(negedge clk);
    rst_n = 1; rsp_valid = 1;
    #1;
    checks++; if (rsp_valid_dn !== 13'h0 || rsp_ready_up !== 1'b0 || gnt_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_after: got v=%h r=%b g=%b want 0000/0/1", rsp_valid_dn, rsp_ready_up, gnt_ready); end
    @(negedge clk);
    rsp_valid = 0;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  seq [21];
    logic [12:0] want;
    for (int k = 0; k < 21; k++) seq[k] = 4'((k * 5) % 13);
    @(negedge clk);
    gnt3 = 1; gnt_idx3 = seq[0]; rsp_ready_dn3 = '1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      gnt_idx3 = seq[k]; rsp_valid3 = 1;
      want = 13'd1 << seq[k-1];
      #1;
      checks++; if (rsp_valid_dn3 !== want || outstanding3 !== 2'd1) begin errors++; $display("FAIL wrap_%0d: got v=%h cnt=%0d want %h/1", k, rsp_valid_dn3, outstanding3, want); end
    end
    @(negedge clk);
    gnt3 = 0; gnt_idx3 = '0;
    #1;
    want = 13'd1 << seq[20];
    checks++; if (rsp_valid_dn3 !== want) begin errors++; $display("FAIL wrap_last: got %h want %h", rsp_valid_dn3, want); end
    @(negedge clk);
    rsp_valid3 = 0;
    #1;
    checks++; if (empty3 !== 1'b1 || outstanding3 !== 2'd0) begin errors++; $display("FAIL wrap_drain: got e=%b cnt=%0d want 1/0", empty3, outstanding3); end
  endtask

  initial begin
    test_reset;
    test_order;
    test_full;
    test_stall;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
